// File: rtl/riscv_divider_iter.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Handles the divide-by-zero and signed-overflow cases in a single cycle.
module riscv_divider_iter #(
   parameter int XLEN = 64
) (
   input  logic            i_riscv_div_clk,
   input  logic            i_riscv_div_rst,
   input  logic            i_riscv_div_en,
   input  logic [2:0]      i_riscv_div_ctrl,
   input  logic [XLEN-1:0] i_riscv_div_rs1data,
   input  logic [XLEN-1:0] i_riscv_div_rs2data,
   output logic [XLEN-1:0] o_riscv_div_result,
   output logic            o_riscv_div_valid
);

   // Handshake: en is a level held by the pipeline while the op is in E. valid
   // pulses for one cycle with the result. The pipeline advances on that edge.
   // Dropping en while BUSY kills the op without producing a valid pulse.
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]   cnt;
   logic            w_q, rem_sel_q, neg_quo_q, neg_rem_q;

   function automatic logic [XLEN-1:0] w_fix(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   logic            is_w, is_sgn, sgn_a, sgn_b, div_zero, ovf, special;
   logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_val, quo_init, q_sp, r_sp, sp_res;
   logic [CW-1:0]   cnt_init;

   always_comb begin
      is_w     = i_riscv_div_ctrl[2];
      is_sgn   = ~i_riscv_div_ctrl[0];
      op_a     = i_riscv_div_rs1data;
      op_b     = i_riscv_div_rs2data;
      if (is_w) begin
         op_a = is_sgn ? {{(XLEN-32){i_riscv_div_rs1data[31]}}, i_riscv_div_rs1data[31:0]}
                       : {{(XLEN-32){1'b0}}, i_riscv_div_rs1data[31:0]};
         op_b = is_sgn ? {{(XLEN-32){i_riscv_div_rs2data[31]}}, i_riscv_div_rs2data[31:0]}
                       : {{(XLEN-32){1'b0}}, i_riscv_div_rs2data[31:0]};
      end
      sgn_a    = is_sgn & op_a[XLEN-1];
      sgn_b    = is_sgn & op_b[XLEN-1];
      mag_a    = sgn_a ? -op_a : op_a;
      mag_b    = sgn_b ? -op_b : op_b;
      // Sign-extended operands make the W overflow check a full-width compare.
      min_val  = is_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (op_b == '0);
      ovf      = is_sgn & (op_a == min_val) & (op_b == '1);
      special  = div_zero | ovf;
      q_sp     = div_zero ? '1 : op_a;
      r_sp     = div_zero ? op_a : '0;
      sp_res   = i_riscv_div_ctrl[1] ? r_sp : q_sp;
      // W dividends start in the top half so 32 shifts move them fully through.
      quo_init = is_w ? (mag_a << 32) : mag_a;
      cnt_init = is_w ? CW'(32) : CW'(XLEN);
   end

   logic [XLEN:0]   rem_sh, diff;
   logic            no_borrow;
   logic [XLEN-1:0] rem_nx, quo_nx, q_fin, r_fin, fin_res;

   always_comb begin
      rem_sh    = {rem_q, quo_q[XLEN-1]};
      diff      = rem_sh - {1'b0, dvs_q};
      no_borrow = ~diff[XLEN];
      rem_nx    = no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_nx    = {quo_q[XLEN-2:0], no_borrow};
      q_fin     = neg_quo_q ? -quo_nx : quo_nx;
      r_fin     = neg_rem_q ? -rem_nx : rem_nx;
      fin_res   = w_fix(rem_sel_q ? r_fin : q_fin, w_q);
   end

   always_ff @(posedge i_riscv_div_clk or posedge i_riscv_div_rst) begin
      if (i_riscv_div_rst) begin
         state              <= IDLE;
         o_riscv_div_valid  <= 1'b0;
         o_riscv_div_result <= '0;
         rem_q              <= '0;
         quo_q              <= '0;
         dvs_q              <= '0;
         cnt                <= '0;
         w_q                <= 1'b0;
         rem_sel_q          <= 1'b0;
         neg_quo_q          <= 1'b0;
         neg_rem_q          <= 1'b0;
      end else begin
         o_riscv_div_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_riscv_div_en) begin
                  rem_q     <= '0;
                  quo_q     <= quo_init;
                  dvs_q     <= mag_b;
                  cnt       <= cnt_init;
                  w_q       <= is_w;
                  rem_sel_q <= i_riscv_div_ctrl[1];
                  neg_quo_q <= sgn_a ^ sgn_b;
                  neg_rem_q <= sgn_a;
                  if (special) begin
                     o_riscv_div_result <= w_fix(sp_res, is_w);
                     o_riscv_div_valid  <= 1'b1;
                     state              <= DONE;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (!i_riscv_div_en) begin
                  state <= IDLE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt   <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     o_riscv_div_result <= fin_res;
                     o_riscv_div_valid  <= 1'b1;
                     state              <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
